mem_dump: RTL and testbench

MEM_DUMP -- requirements
Module: mem_dump

---
 rtl/mem_dump_if.sv | 28 ++
 rtl/mem_dump.sv | 112 +++++++++++
 tb/tb_mem_dump.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dump_if.sv
// Command, RAM-side and stream signals of the memory dump engine.
// The slave modport is the engine's view of the bus; the master modport is the driver's view.
interface mem_dump_if #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 8
);
    logic                     Start_i;
    logic [ADDRESS_WIDTH-1:0] StartAddress_i;
    logic [ADDRESS_WIDTH:0]   Length_i;
    logic                     ReadEnable_o;
    logic [ADDRESS_WIDTH-1:0] Address_o;
    logic [DATA_WIDTH-1:0]    RamData_i;
    logic [DATA_WIDTH-1:0]    Data_o;
    logic                     Valid_o;
    logic                     Ready_i;
    logic                     Busy_o;
    logic                     Done_o;

    modport slave (
        input  Start_i, StartAddress_i, Length_i, RamData_i, Ready_i,
        output ReadEnable_o, Address_o, Data_o, Valid_o, Busy_o, Done_o
    );

    modport master (
        output Start_i, StartAddress_i, Length_i, RamData_i, Ready_i,
        input  ReadEnable_o, Address_o, Data_o, Valid_o, Busy_o, Done_o
    );
endinterface

// File: rtl/mem_dump.sv
// Streams Length words from a registered-read RAM starting at StartAddress,
// one READ/WAIT/OUTPUT round per word, with a one-cycle Done pulse at the end.
module mem_dump #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 8
) (
    input  logic      Clock,
    input  logic      Reset,
    mem_dump_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t                   state;
    state_t                   next_state;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [ADDRESS_WIDTH:0]   remaining;
    logic [DATA_WIDTH-1:0]    data;

    logic load;
    logic capture;
    logic advance;
    logic read_enable;
    logic valid;
    logic busy;
    logic done;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= S_IDLE;
            address   <= '0;
            remaining <= '0;
            data      <= '0;
        end else begin
            state <= next_state;
            if (load) begin
                address   <= bus.StartAddress_i;
                remaining <= bus.Length_i;
            end else if (advance) begin
                // Natural overflow gives the modulo-2**ADDRESS_WIDTH wrap.
                address   <= address + ADDRESS_WIDTH'(1);
                remaining <= remaining - (ADDRESS_WIDTH + 1)'(1);
            end
            if (capture) begin
                data <= bus.RamData_i;
            end
        end
    end

    always_comb begin
        next_state  = state;
        load        = 1'b0;
        capture     = 1'b0;
        advance     = 1'b0;
        read_enable = 1'b0;
        valid       = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (bus.Start_i) begin
                    if (bus.Length_i == '0) begin
                        next_state = S_DONE;
                    end else begin
                        load       = 1'b1;
                        next_state = S_READ;
                    end
                end
            end
            S_READ: begin
                read_enable = 1'b1;
                next_state  = S_WAIT;
            end
            S_WAIT: begin
                capture    = 1'b1;
                next_state = S_OUTPUT;
            end
            S_OUTPUT: begin
                valid = 1'b1;
                if (bus.Ready_i) begin
                    if (remaining == (ADDRESS_WIDTH + 1)'(1)) begin
                        next_state = S_DONE;
                    end else begin
                        advance    = 1'b1;
                        next_state = S_READ;
                    end
                end
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                busy       = 1'b0;
                next_state = S_IDLE;
            end
        endcase
    end

    assign bus.ReadEnable_o = read_enable;
    assign bus.Address_o    = address;
    assign bus.Data_o       = data;
    assign bus.Valid_o      = valid;
    assign bus.Busy_o       = busy;
    assign bus.Done_o       = done;
endmodule

// File: tb/tb_mem_dump.sv
// Directed scenarios for mem_dump on a 16-bit and a 4-bit address instance,
// with a scoreboard of expected read addresses and stream words.
module tb_mem_dump;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_dump_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8)) ba ();
    mem_dump_if #(.ADDRESS_WIDTH(4),  .DATA_WIDTH(8)) bb ();

    mem_dump #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8)) dut_a (.Clock(clk), .Reset(rst_n), .bus(ba));
    mem_dump #(.ADDRESS_WIDTH(4),  .DATA_WIDTH(8)) dut_b (.Clock(clk), .Reset(rst_n), .bus(bb));

    // Stimulus shared by both instances; sel picks which one is started and observed.
    bit          sel;
    logic        start;
    logic        ready;
    logic [15:0] saddr;
    logic [16:0] len;

    assign ba.Start_i        = start & ~sel;
    assign bb.Start_i        = start & sel;
    assign ba.StartAddress_i = saddr;
    assign bb.StartAddress_i = saddr[3:0];
    assign ba.Length_i       = len;
    assign bb.Length_i       = len[4:0];
    assign ba.Ready_i        = ready;
    assign bb.Ready_i        = ready;

    // Registered-read RAM models.
    logic [7:0] mem_a [0:65535];
    logic [7:0] mem_b [0:15];
    logic [7:0] rd_a;
    logic [7:0] rd_b;
    always @(posedge clk) begin
        if (ba.ReadEnable_o) rd_a <= mem_a[ba.Address_o];
        if (bb.ReadEnable_o) rd_b <= mem_b[bb.Address_o];
    end
    assign ba.RamData_i = rd_a;
    assign bb.RamData_i = rd_b;

    logic        m_re, m_valid, m_done, m_busy;
    logic [15:0] m_addr;
    logic [7:0]  m_data;
    assign m_re    = sel ? bb.ReadEnable_o : ba.ReadEnable_o;
    assign m_valid = sel ? bb.Valid_o      : ba.Valid_o;
    assign m_done  = sel ? bb.Done_o       : ba.Done_o;
    assign m_busy  = sel ? bb.Busy_o       : ba.Busy_o;
    assign m_addr  = sel ? {12'h000, bb.Address_o} : ba.Address_o;
    assign m_data  = sel ? bb.Data_o       : ba.Data_o;

    logic [15:0] exp_addr [$];
    logic [7:0]  exp_data [$];

    int n_pass  = 0;
    int n_total = 0;

    int re_count, valid_count, accept_count, done_count;
    int first_re, first_valid, done_cyc, last_accept;
    bit unstable, busy_gap;
    logic busy_after;

    task automatic push_expected(input bit use_b, input logic [15:0] sa, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = use_b ? ((sa + 16'(i)) & 16'h000F) : (sa + 16'(i));
            exp_addr.push_back(a);
            exp_data.push_back(use_b ? mem_b[a[3:0]] : mem_a[a]);
        end
    endtask

    // Starts one dump, then compares each read strobe and accepted word against the scoreboard.
    task automatic run_dump(input bit use_b, input logic [15:0] sa, input logic [16:0] n,
                            input int stall, input bit poke);
        int cyc;
        int wait_cnt;
        bit seen_done;
        bit prev_valid;
        logic [7:0]  prev;
        logic [15:0] ea;
        logic [7:0]  ed;
        sel = use_b;
        re_count = 0; valid_count = 0; accept_count = 0; done_count = 0;
        first_re = 0; first_valid = 0; done_cyc = 0; last_accept = 0;
        unstable = 0; busy_gap = 0; busy_after = 1'b1;
        saddr = sa; len = n; start = 1'b1; ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; wait_cnt = 0; seen_done = 0; prev_valid = 0; prev = '0;
        while (cyc < 400) begin
            if (poke) begin
                start = (cyc == 4);
                saddr = 16'h0100;
                len   = 17'd5;
            end
            if (!seen_done && m_busy !== 1'b1) busy_gap = 1;
            if (m_re) begin
                re_count++;
                if (first_re == 0) first_re = cyc;
                n_total++;
                if (exp_addr.size() == 0) begin
                    $display("FAIL read_addr: got unexpected read at %h, expected no read", m_addr);
                end else begin
                    ea = exp_addr.pop_front();
                    if (m_addr !== ea) $display("FAIL read_addr: got %h expected %h", m_addr, ea);
                    else n_pass++;
                end
            end
            if (m_valid) begin
                valid_count++;
                if (first_valid == 0) first_valid = cyc;
                if (prev_valid && m_data !== prev) unstable = 1;
                prev = m_data;
                prev_valid = 1;
                ready = (wait_cnt >= stall);
                if (ready) begin
                    wait_cnt = 0;
                    prev_valid = 0;
                    accept_count++;
                    last_accept = cyc;
                    n_total++;
                    if (exp_data.size() == 0) begin
                        $display("FAIL stream_data: got unexpected word %h, expected no word", m_data);
                    end else begin
                        ed = exp_data.pop_front();
                        if (m_data !== ed) $display("FAIL stream_data: got %h expected %h", m_data, ed);
                        else n_pass++;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                ready = 1'b0;
                prev_valid = 0;
            end
            if (m_done) begin
                done_count++;
                if (!seen_done) done_cyc = cyc;
                seen_done = 1;
            end else if (seen_done) begin
                busy_after = m_busy;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        ready = 1'b0;
        n_total++;
        if (!seen_done) $display("FAIL dump_timeout: got no Done_o within %0d cycles, expected Done_o", cyc);
        else n_pass++;
        n_total++;
        if (exp_addr.size() != 0 || exp_data.size() != 0)
            $display("FAIL scoreboard_drain: got %0d addrs/%0d words left, expected 0/0", exp_addr.size(), exp_data.size());
        else n_pass++;
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (ba.ReadEnable_o !== 1'b0) $display("FAIL reset_re: got %b expected 0", ba.ReadEnable_o); else n_pass++;
        n_total++; if (ba.Valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", ba.Valid_o); else n_pass++;
        n_total++; if (ba.Busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", ba.Busy_o); else n_pass++;
        n_total++; if (ba.Done_o !== 1'b0) $display("FAIL reset_done: got %b expected 0", ba.Done_o); else n_pass++;
        n_total++; if (ba.Data_o !== 8'h00) $display("FAIL reset_data: got %h expected 00", ba.Data_o); else n_pass++;
        n_total++; if (ba.Address_o !== 16'h0000) $display("FAIL reset_addr: got %h expected 0000", ba.Address_o); else n_pass++;
        n_total++; if (bb.Busy_o !== 1'b0) $display("FAIL reset_busy_b: got %b expected 0", bb.Busy_o); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill_ff;
        push_expected(0, 16'h0010, 3);
        run_dump(0, 16'h0010, 17'd3, 0, 0);
        n_total++; if (re_count !== 3) $display("FAIL fill_reads: got %0d expected 3", re_count); else n_pass++;
        n_total++; if (accept_count !== 3) $display("FAIL fill_words: got %0d expected 3", accept_count); else n_pass++;
        n_total++; if (done_count !== 1) $display("FAIL fill_done_count: got %0d expected 1", done_count); else n_pass++;
        n_total++; if (first_re !== 1) $display("FAIL fill_re_latency: got %0d expected 1", first_re); else n_pass++;
        n_total++; if (first_valid !== 3) $display("FAIL fill_valid_latency: got %0d expected 3", first_valid); else n_pass++;
        n_total++; if (done_cyc !== 10) $display("FAIL fill_done_cycle: got %0d expected 10", done_cyc); else n_pass++;
        n_total++; if (busy_gap !== 0) $display("FAIL fill_busy: got busy low mid-dump, expected high"); else n_pass++;
        n_total++; if (busy_after !== 1'b0) $display("FAIL fill_idle_busy: got %b expected 0", busy_after); else n_pass++;
    endtask

    task automatic test_stall;
        mem_a[16'h0005] = 8'hA5;
        push_expected(0, 16'h0005, 1);
        run_dump(0, 16'h0005, 17'd1, 4, 0);
        n_total++; if (valid_count !== 5) $display("FAIL stall_valid_cycles: got %0d expected 5", valid_count); else n_pass++;
        n_total++; if (unstable !== 0) $display("FAIL stall_data_stable: got change while stalled, expected stable"); else n_pass++;
        n_total++; if (last_accept !== 7) $display("FAIL stall_accept_cycle: got %0d expected 7", last_accept); else n_pass++;
        n_total++; if (done_cyc !== 8) $display("FAIL stall_done_cycle: got %0d expected 8", done_cyc); else n_pass++;
    endtask

    task automatic test_zero_length;
        run_dump(0, 16'h0040, 17'd0, 0, 0);
        n_total++; if (re_count !== 0) $display("FAIL zero_reads: got %0d expected 0", re_count); else n_pass++;
        n_total++; if (valid_count !== 0) $display("FAIL zero_valid: got %0d expected 0", valid_count); else n_pass++;
        n_total++; if (done_cyc !== 1) $display("FAIL zero_done_cycle: got %0d expected 1", done_cyc); else n_pass++;
        n_total++; if (done_count !== 1) $display("FAIL zero_done_count: got %0d expected 1", done_count); else n_pass++;
    endtask

    task automatic test_mid_start;
        for (int i = 0; i < 3; i++) mem_a[16'h0080 + 16'(i)] = 8'($urandom);
        push_expected(0, 16'h0080, 3);
        run_dump(0, 16'h0080, 17'd3, 0, 1);
        n_total++; if (accept_count !== 3) $display("FAIL mid_start_words: got %0d expected 3", accept_count); else n_pass++;
        n_total++; if (done_count !== 1) $display("FAIL mid_start_done: got %0d expected 1", done_count); else n_pass++;
        n_total++; if (busy_after !== 1'b0) $display("FAIL mid_start_queued: got busy %b expected 0", busy_after); else n_pass++;
    endtask

    task automatic test_wrap_small;
        push_expected(1, 16'h000E, 4);
        run_dump(1, 16'h000E, 17'd4, 0, 0);
        n_total++; if (accept_count !== 4) $display("FAIL wrap4_words: got %0d expected 4", accept_count); else n_pass++;
        n_total++; if (done_count !== 1) $display("FAIL wrap4_done: got %0d expected 1", done_count); else n_pass++;
    endtask

    task automatic test_full_memory;
        push_expected(1, 16'h0007, 16);
        run_dump(1, 16'h0007, 17'd16, 1, 0);
        n_total++; if (re_count !== 16) $display("FAIL full_reads: got %0d expected 16", re_count); else n_pass++;
        n_total++; if (accept_count !== 16) $display("FAIL full_words: got %0d expected 16", accept_count); else n_pass++;
        n_total++; if (done_cyc !== 65) $display("FAIL full_done_cycle: got %0d expected 65", done_cyc); else n_pass++;
    endtask

    task automatic test_top_wrap;
        mem_a[16'hFFFE] = 8'h3C; mem_a[16'hFFFF] = 8'hC3;
        mem_a[16'h0000] = 8'h12; mem_a[16'h0001] = 8'h81;
        push_expected(0, 16'hFFFE, 4);
        run_dump(0, 16'hFFFE, 17'd4, 0, 0);
        n_total++; if (accept_count !== 4) $display("FAIL wrap16_words: got %0d expected 4", accept_count); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int cnt;
        bit done_seen;
        mem_a[16'h0020] = 8'h5A; mem_a[16'h0021] = 8'h6B; mem_a[16'h0022] = 8'h7C;
        sel = 0; saddr = 16'h0020; len = 17'd3; ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (ba.Valid_o !== 1'b1 && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        n_total++; if (ba.Valid_o !== 1'b1) $display("FAIL rstmid_reach_output: got Valid_o %b expected 1", ba.Valid_o); else n_pass++;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_total++; if (ba.ReadEnable_o !== 1'b0) $display("FAIL rstmid_re: got %b expected 0", ba.ReadEnable_o); else n_pass++;
        n_total++; if (ba.Valid_o !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", ba.Valid_o); else n_pass++;
        n_total++; if (ba.Busy_o !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", ba.Busy_o); else n_pass++;
        n_total++; if (ba.Done_o !== 1'b0) $display("FAIL rstmid_done: got %b expected 0", ba.Done_o); else n_pass++;
        n_total++; if (ba.Data_o !== 8'h00) $display("FAIL rstmid_data: got %h expected 00", ba.Data_o); else n_pass++;
        n_total++; if (ba.Address_o !== 16'h0000) $display("FAIL rstmid_addr: got %h expected 0000", ba.Address_o); else n_pass++;
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (ba.Done_o === 1'b1 || ba.Busy_o === 1'b1) done_seen = 1;
        end
        n_total++; if (done_seen !== 0) $display("FAIL rstmid_abandon: got activity after reset, expected idle"); else n_pass++;
        mem_a[16'h0030] = 8'h99; mem_a[16'h0031] = 8'h66;
        push_expected(0, 16'h0030, 2);
        run_dump(0, 16'h0030, 17'd2, 0, 0);
        n_total++; if (accept_count !== 2) $display("FAIL rstmid_restart_words: got %0d expected 2", accept_count); else n_pass++;
        n_total++; if (done_count !== 1) $display("FAIL rstmid_restart_done: got %0d expected 1", done_count); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ready = 1'b0; sel = 0; saddr = '0; len = '0;
        for (int i = 0; i < 65536; i++) mem_a[i] = 8'hFF;
        for (int i = 0; i < 16; i++) mem_b[i] = 8'h30 + 8'(i);
        test_reset;
        test_fill_ff;
        test_stall;
        test_zero_length;
        test_mid_start;
        test_wrap_small;
        test_full_memory;
        test_top_wrap;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
